// File: rtl/led_pattern_engine_pkg.sv
// Shared types and helpers for the LED pattern engine and its tick generator.
// Mode and direction encodings match the board-level switch/CSR fields.
package led_pattern_engine_pkg;

   typedef enum logic [1:0] {
      MODE_ROTL   = 2'b00,
      MODE_ROTR   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam int unsigned CNT_W = 32;

   // Terminal count for the selected speed; period is BASE_PERIOD >> speed.
   function automatic logic [CNT_W-1:0] step_limit(input logic [CNT_W-1:0] base_period,
                                                  input logic [1:0]       speed);
      return (base_period >> speed) - CNT_W'(1);
   endfunction

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// Programmable-rate tick generator: one-cycle tick every (BASE_PERIOD >> speed)
// enabled cycles. Counter holds while en=0 and is cleared synchronously by clear.
module led_tick_gen
   import led_pattern_engine_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned STEP_HZ  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] speed,
   input  logic       clear,
   output logic       tick
);

   localparam logic [CNT_W-1:0] BASE_PERIOD = CNT_W'(CLK_FREQ / STEP_HZ);

   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] limit;
   logic             wrap;

   assign limit = step_limit(BASE_PERIOD, speed);
   // ">=" so that switching to a shorter period wraps on the next enabled cycle
   assign wrap  = (counter >= limit);
   assign tick  = en && !clear && wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter <= '0;
      end else if (clear) begin
         counter <= '0;
      end else if (en) begin
         counter <= wrap ? '0 : counter + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_engine.sv
// Parametrised LED pattern generator: rotate-left/right, bounce and hold modes
// with run/pause, programmable step rate and synchronous pattern load.
module led_pattern_engine
   import led_pattern_engine_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 25_000_000,
   parameter int unsigned STEP_HZ      = 4,
   parameter int unsigned WIDTH        = 8,
   parameter logic [31:0] INIT_PATTERN = 32'h1F
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] leds,
   output logic             step
);

   localparam int unsigned PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic             tick;
   mode_e            mode_in;
   mode_e            mode_q;
   dir_e             dir_q, dir_n, dir_eff;
   logic [PW-1:0]    pos_q, pos_n, pos_eff;
   logic [WIDTH-1:0] leds_n;
   logic             step_n;
   logic [WIDTH-1:0] rot_l, rot_r;

   led_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .STEP_HZ  (STEP_HZ)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .speed (speed),
      .clear (load),
      .tick  (tick)
   );

   assign mode_in = mode_e'(mode);
   assign rot_l   = {leds[WIDTH-2:0], leds[WIDTH-1]};
   assign rot_r   = {leds[0], leds[WIDTH-1:1]};

   always_comb begin
      leds_n  = leds;
      step_n  = 1'b0;
      dir_eff = dir_q;
      pos_eff = pos_q;
      // Entering bounce restarts the sweep; a tick in the entry cycle sees the restart values
      if (mode_in == MODE_BOUNCE && mode_q != MODE_BOUNCE) begin
         dir_eff = DIR_LEFT;
         pos_eff = '0;
      end
      dir_n = dir_eff;
      pos_n = pos_eff;

      if (load) begin
         leds_n = load_value;
         dir_n  = DIR_LEFT;
         pos_n  = '0;
      end else if (tick) begin
         case (mode_in)
            MODE_ROTL: begin
               leds_n = rot_l;
               step_n = 1'b1;
            end
            MODE_ROTR: begin
               leds_n = rot_r;
               step_n = 1'b1;
            end
            MODE_BOUNCE: begin
               leds_n = (dir_eff == DIR_LEFT) ? rot_l : rot_r;
               step_n = 1'b1;
               if (pos_eff == PW'(WIDTH - 2)) begin
                  dir_n = (dir_eff == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                  pos_n = '0;
               end else begin
                  pos_n = pos_eff + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds   <= WIDTH'(INIT_PATTERN);
         step   <= 1'b0;
         dir_q  <= DIR_LEFT;
         pos_q  <= '0;
         mode_q <= MODE_ROTL;
      end else begin
         leds   <= leds_n;
         step   <= step_n;
         dir_q  <= dir_n;
         pos_q  <= pos_n;
         mode_q <= mode_in;
      end
   end

endmodule
